// File: rtl/serial_addsub.sv
// serial_addsub: multi-cycle adder/subtractor, DIGIT bits per clock.
// Valid/ready on both sides; flags latched on the final digit.
module serial_addsub #(
  parameter int NUMBITS = 16,
  parameter int DIGIT   = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [NUMBITS-1:0] A,
  input  logic [NUMBITS-1:0] B,
  input  logic               sub,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [NUMBITS-1:0] sum,
  output logic               carryflag,
  output logic               zero,
  output logic               overflow
);

  localparam int STEPS = NUMBITS / DIGIT;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

  if (NUMBITS < 1 || DIGIT < 1 || DIGIT > NUMBITS ||
      (NUMBITS % DIGIT) != 0) begin : g_bad_params
    $error("serial_addsub: NUMBITS must be a multiple of DIGIT");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  state_t             nstate;
  logic [NUMBITS-1:0] a_sh;
  logic [NUMBITS-1:0] b_sh;
  logic               carry;
  logic [CW-1:0]      cnt;
  logic [DIGIT:0]     dsum;
  logic [DIGIT-1:0]   s;
  logic               c;
  logic               cmsb;
  logic               last;
  logic [NUMBITS-1:0] nsum;

  // One digit of the ripple: low DIGIT bits of both operands plus carry
  always_comb begin
    dsum = {1'b0, a_sh[DIGIT-1:0]}
         + {1'b0, b_sh[DIGIT-1:0]}
         + {{DIGIT{1'b0}}, carry};
  end

  assign s    = dsum[DIGIT-1:0];
  assign c    = dsum[DIGIT];
  // sum bit = a ^ b ^ cin, so the carry into the digit MSB falls out
  assign cmsb = a_sh[DIGIT-1] ^ b_sh[DIGIT-1] ^ s[DIGIT-1];
  assign last = (cnt == CW'(STEPS - 1));

  if (DIGIT == NUMBITS) begin : g_one_step
    assign nsum = s;
  end else begin : g_multi_step
    assign nsum = {s, sum[NUMBITS-1:DIGIT]};
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nstate;
  end

  // Next-state decode
  always_comb begin
    nstate = state;
    unique case (state)
      IDLE:    if (in_valid)  nstate = RUN;
      RUN:     if (last)      nstate = DONE;
      DONE:    if (out_ready) nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  // Handshake outputs decoded from the state register
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  // Operand capture, digit-serial shift and flag latch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh      <= '0;
      b_sh      <= '0;
      carry     <= 1'b0;
      cnt       <= '0;
      sum       <= '0;
      carryflag <= 1'b0;
      zero      <= 1'b0;
      overflow  <= 1'b0;
    end else if (state == IDLE && in_valid) begin
      a_sh  <= A;
      b_sh  <= sub ? ~B : B;
      carry <= sub;
      cnt   <= '0;
    end else if (state == RUN) begin
      sum   <= nsum;
      a_sh  <= a_sh >> DIGIT;
      b_sh  <= b_sh >> DIGIT;
      carry <= c;
      cnt   <= cnt + 1'b1;
      if (last) begin
        carryflag <= c;
        overflow  <= cmsb ^ c;
        zero      <= (nsum == '0);
      end
    end
  end

endmodule
